krnl_rtl_trial_a_stream_alu: RTL and testbench
==============================================

KRNL_RTL_TRIAL_A_STREAM_ALU -- requirements
Module: krnl_rtl_trial_a_stream_alu

Interface
REQ-001 SHALL have parameter C_AXIS_TDATA_WIDTH, default 512, stream data width in bits (multiple of C_LANE_WIDTH).
REQ-002 SHALL have parameter C_LANE_WIDTH, default 32, per-lane ALU width in bits (8, 16, 32 or 64).
REQ-003 SHALL have parameter C_FIFO_DEPTH, default 32, output FIFO depth in beats (power of 2, >= 4).
REQ-004 SHALL have ports, clock and reset first: aclk in 1 sole clock; aresetn in 1 asynchronous active-low reset.
REQ-005 ctrl_mode in 2 op select; ctrl_constant in C_LANE_WIDTH lane operand.
REQ-006 s_axis_tvalid in 1; s_axis_tready out 1; s_axis_tdata in C_AXIS_TDATA_WIDTH; s_axis_tkeep in C_AXIS_TDATA_WIDTH/8; s_axis_tlast in 1.
REQ-007 m_axis_tvalid out 1; m_axis_tready in 1; m_axis_tdata out C_AXIS_TDATA_WIDTH; m_axis_tkeep out C_AXIS_TDATA_WIDTH/8; m_axis_tlast out 1.
REQ-008 stat_pkt_count out 32 packets completed at output; stat_sat_count out 32 beats with any saturated lane.

Function
REQ-009 SHALL accept a beat only when s_axis_tvalid & s_axis_tready in the same cycle; SHALL never drop or duplicate a beat.
REQ-010 ctrl_mode encoding: 00 ADD modulo 2^C_LANE_WIDTH; 01 SUB (lane minus constant) modulo; 10 SATADD unsigned, clamp to all-ones; 11 PASS unchanged.
REQ-011 SHALL apply the op to every lane i independently: lane i = tdata[i*C_LANE_WIDTH +: C_LANE_WIDTH]; no carry between lanes.
REQ-012 SHALL latch ctrl_mode and ctrl_constant on the first accepted beat of each packet (first beat after reset or after an accepted tlast); values hold for the whole packet.
REQ-013 tkeep and tlast SHALL pass through unmodified and aligned with their data.
REQ-014 Pipeline: stage 1 registers input, stage 2 computes, then FIFO write; beat accepted in cycle N SHALL present m_axis_tvalid in cycle N+3 when FIFO empty.
REQ-015 FIFO SHALL be first-word-fall-through; m_axis_* SHALL hold stable while m_axis_tvalid & ~m_axis_tready.
REQ-016 s_axis_tready SHALL equal (fifo_count + s1_valid + s2_valid) < C_FIFO_DEPTH, so the FIFO never overflows.
REQ-017 Simultaneous push and pop SHALL leave fifo_count unchanged; pop on empty and push on full SHALL not occur.
REQ-018 Full-rate throughput: with m_axis_tready held 1, one beat per cycle sustained.
REQ-019 stat_pkt_count SHALL increment on each output handshake with m_axis_tlast=1; stat_sat_count on each stage-2 beat in SATADD where any lane clamped; both wrap at 2^32.

Reset
REQ-020 aresetn low SHALL asynchronously clear stage valids, FIFO pointers/count, packet-start flag (set to 1), and both stat counters.
REQ-021 During reset m_axis_tvalid=0 and s_axis_tready=0; s_axis_tready SHALL rise on the first aclk edge after aresetn deasserts.
REQ-022 Reset mid-packet SHALL discard all in-flight and buffered beats; the next accepted beat starts a new packet.
REQ-023 Data-path registers (tdata/tkeep/tlast) need no reset.

Structure
REQ-024 Package krnl_rtl_trial_a_stream_alu_pkg SHALL hold the mode encoding constants (MODE_ADD, MODE_SUB, MODE_SATADD, MODE_PASS).
REQ-025 One sub-module krnl_rtl_trial_a_stream_alu_fifo: single-clock FWFT FIFO, width C_AXIS_TDATA_WIDTH*9/8+1, depth C_FIFO_DEPTH, count output.

Verification
REQ-026 ADD, constant 5, one beat lanes all 0xFFFFFFFE, tlast=1 -> output lanes 0x00000003, tlast=1, at cycle N+3; stat_pkt_count=1.
REQ-027 SATADD, constant 0x10, lane0 0xFFFFFFF8 others 0 -> lane0 0xFFFFFFFF, others 0x10; stat_sat_count=1.
REQ-028 4-beat packet, ctrl_mode switched ADD->SUB after beat 1 -> all 4 beats use ADD; next packet uses SUB.
REQ-029 m_axis_tready=0, continuous input -> exactly C_FIFO_DEPTH beats accepted then s_axis_tready=0; release -> all beats out in order, none lost.
REQ-030 aresetn pulsed low with 10 beats buffered -> m_axis_tvalid=0 immediately, counters 0, first post-reset beat emitted alone with fresh control latch.

Source files
------------

// File: rtl/krnl_rtl_trial_a_stream_alu_pkg.sv
// Shared definitions for the streaming lane ALU: op-select encoding.
package krnl_rtl_trial_a_stream_alu_pkg;

  // ctrl_mode encoding, applied per lane against ctrl_constant
  typedef enum logic [1:0] {
    MODE_ADD    = 2'b00,  // lane + constant, modulo 2^lane_width
    MODE_SUB    = 2'b01,  // lane - constant, modulo 2^lane_width
    MODE_SATADD = 2'b10,  // unsigned lane + constant, clamped to all-ones
    MODE_PASS   = 2'b11   // lane unchanged
  } alu_mode_e;

endpackage

// File: rtl/krnl_rtl_trial_a_stream_alu_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// The head entry is visible on rd_data whenever empty is low.
module krnl_rtl_trial_a_stream_alu_fifo #(
  parameter int WIDTH = 577,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Guard both ports so a misbehaving producer/consumer cannot corrupt state.
  assign push    = wr_en & (count != FULL_CNT);
  assign pop     = rd_en & ~empty;
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage write port.
  // NOTE: the storage array has no reset; validity is tracked by the pointers
  // and count alone, which keeps the array mappable to RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count alone.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/krnl_rtl_trial_a_stream_alu.sv
// AXI-Stream lane ALU: register input, compute per-lane op, buffer in an
// FWFT FIFO. Control is latched on the first beat of every packet.
module krnl_rtl_trial_a_stream_alu
  import krnl_rtl_trial_a_stream_alu_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_LANE_WIDTH       = 32,
  parameter int C_FIFO_DEPTH       = 32
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [1:0]                      ctrl_mode,
  input  logic [C_LANE_WIDTH-1:0]         ctrl_constant,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic [31:0]                     stat_pkt_count,
  output logic [31:0]                     stat_sat_count
);

  localparam int DW = C_AXIS_TDATA_WIDTH;
  localparam int LW = C_LANE_WIDTH;
  localparam int KW = DW / 8;
  localparam int NL = DW / LW;
  localparam int FW = DW + KW + 1;
  localparam int CW = $clog2(C_FIFO_DEPTH) + 1;
  localparam logic [CW:0] OCC_LIMIT = (CW+1)'(C_FIFO_DEPTH);

  logic            rdy_en;
  logic            pkt_start;
  alu_mode_e       mode_q;
  logic [LW-1:0]   const_q;
  alu_mode_e       eff_mode;
  logic [LW-1:0]   eff_const;
  logic            s_accept;
  logic            m_accept;

  logic            s1_valid;
  logic [DW-1:0]   s1_data;
  logic [KW-1:0]   s1_keep;
  logic            s1_last;
  alu_mode_e       s1_mode;
  logic [LW-1:0]   s1_const;

  logic            s2_valid;
  logic [DW-1:0]   s2_data;
  logic [KW-1:0]   s2_keep;
  logic            s2_last;
  logic            s2_sat;

  logic [DW-1:0]   alu_data;
  logic            alu_sat;
  logic [LW-1:0]   lane_a;
  logic [LW:0]     lane_sum;

  logic [FW-1:0]   fifo_rd_data;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occupancy;

  // Credit check counts beats already in flight so the FIFO can never overflow.
  assign occupancy     = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid} + {{CW{1'b0}}, s2_valid};
  assign s_axis_tready = rdy_en & (occupancy < OCC_LIMIT);
  assign s_accept      = s_axis_tvalid & s_axis_tready;
  assign m_accept      = m_axis_tvalid & m_axis_tready;

  // First beat of a packet uses the live control inputs; later beats the latch.
  assign eff_mode  = pkt_start ? alu_mode_e'(ctrl_mode) : mode_q;
  assign eff_const = pkt_start ? ctrl_constant : const_q;

  // Pipeline valids, packet-start tracking and ready enable (held low in reset).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_en    <= 1'b0;
      pkt_start <= 1'b1;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
    end else begin
      rdy_en   <= 1'b1;
      s1_valid <= s_accept;
      s2_valid <= s1_valid;
      if (s_accept) pkt_start <= s_axis_tlast;
    end
  end

  // Control latch and data-path registers; qualified by the valids, so unreset.
  always_ff @(posedge aclk) begin
    if (s_accept) begin
      if (pkt_start) begin
        mode_q  <= alu_mode_e'(ctrl_mode);
        const_q <= ctrl_constant;
      end
      s1_data  <= s_axis_tdata;
      s1_keep  <= s_axis_tkeep;
      s1_last  <= s_axis_tlast;
      s1_mode  <= eff_mode;
      s1_const <= eff_const;
    end
    if (s1_valid) begin
      s2_data <= alu_data;
      s2_keep <= s1_keep;
      s2_last <= s1_last;
      s2_sat  <= alu_sat;
    end
  end

  // Per-lane ALU: independent lanes, no carry crosses a lane boundary.
  // NOTE: every variable gets a default before the loop so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_data = s1_data;
    alu_sat  = 1'b0;
    lane_a   = '0;
    lane_sum = '0;
    for (int i = 0; i < NL; i++) begin
      lane_a   = s1_data[i*LW +: LW];
      lane_sum = {1'b0, lane_a} + {1'b0, s1_const};
      case (s1_mode)
        MODE_ADD: alu_data[i*LW +: LW] = lane_sum[LW-1:0];
        MODE_SUB: alu_data[i*LW +: LW] = lane_a - s1_const;
        MODE_SATADD: begin
          alu_data[i*LW +: LW] = lane_sum[LW] ? {LW{1'b1}} : lane_sum[LW-1:0];
          alu_sat              = alu_sat | lane_sum[LW];
        end
        default: alu_data[i*LW +: LW] = lane_a;
      endcase
    end
  end

  // Statistics: completed output packets and stage-2 beats that clamped.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_pkt_count <= '0;
      stat_sat_count <= '0;
    end else begin
      if (m_accept && m_axis_tlast) stat_pkt_count <= stat_pkt_count + 32'd1;
      if (s2_valid && s2_sat)       stat_sat_count <= stat_sat_count + 32'd1;
    end
  end

  krnl_rtl_trial_a_stream_alu_fifo #(
    .WIDTH (FW),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk     (aclk),
    .rst_n   (aresetn),
    .wr_en   (s2_valid),
    .wr_data ({s2_last, s2_keep, s2_data}),
    .rd_en   (m_accept),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign m_axis_tvalid = ~fifo_empty;
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = fifo_rd_data;

endmodule

// File: tb/tb_krnl_rtl_trial_a_stream_alu.sv
// Self-checking bench for krnl_rtl_trial_a_stream_alu: directed vector table,
// hand-written packet/backpressure/reset sequences and a randomized phase
// scored against a lane-arithmetic reference model.
`timescale 1ns/1ps
module tb_krnl_rtl_trial_a_stream_alu;
  import krnl_rtl_trial_a_stream_alu_pkg::*;

  localparam int W     = 512;
  localparam int LW    = 32;
  localparam int DEPTH = 32;
  localparam int KW    = W / 8;
  localparam int NL    = W / LW;
  localparam int FW    = W + KW + 1;
  localparam longint unsigned LANE_MOD = 64'd1 << LW;

  logic          aclk;
  logic          aresetn;
  logic [1:0]    ctrl_mode;
  logic [LW-1:0] ctrl_constant;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [W-1:0]  s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [W-1:0]  m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic [31:0]   stat_pkt_count;
  logic [31:0]   stat_sat_count;

  krnl_rtl_trial_a_stream_alu #(
    .C_AXIS_TDATA_WIDTH (W),
    .C_LANE_WIDTH       (LW),
    .C_FIFO_DEPTH       (DEPTH)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .ctrl_mode      (ctrl_mode),
    .ctrl_constant  (ctrl_constant),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tlast   (s_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tlast   (m_axis_tlast),
    .stat_pkt_count (stat_pkt_count),
    .stat_sat_count (stat_sat_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [1:0]    mode;
    logic [LW-1:0] cst;
    logic [LW-1:0] lane0;
    logic [LW-1:0] lane_n;
    logic [KW-1:0] keep;
    logic [LW-1:0] exp0;
    logic [LW-1:0] expn;
    int            exp_sat;
  } vec_t;

  vec_t          vecs[8];
  int            n_cmp;
  int            n_fail;
  logic [FW-1:0] exp_q[$];
  logic [LW-1:0] cap_q[$];
  bit            m_pkt_start;
  logic [1:0]    m_mode;
  logic [LW-1:0] m_const;
  int unsigned   m_sat;
  int unsigned   m_pkt;

  task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: each lane is an independent unsigned number in [0, 2^LW).
  function automatic logic [W-1:0] model_op(input logic [1:0] mode, input logic [LW-1:0] c,
                                            input logic [W-1:0] d, output bit sat);
    logic [W-1:0] r;
    longint unsigned a, k, v;
    r = '0;
    sat = 1'b0;
    k = c;
    for (int i = 0; i < NL; i++) begin
      a = d[i*LW +: LW];
      case (mode)
        2'd0: v = (a + k) % LANE_MOD;
        2'd1: v = (a + LANE_MOD - k) % LANE_MOD;
        2'd2: begin
          if (a + k >= LANE_MOD) begin
            v = LANE_MOD - 1;
            sat = 1'b1;
          end else begin
            v = a + k;
          end
        end
        default: v = a;
      endcase
      r[i*LW +: LW] = v[LW-1:0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] fill(input logic [LW-1:0] l0, input logic [LW-1:0] ln);
    logic [W-1:0] r;
    for (int i = 0; i < NL; i++) r[i*LW +: LW] = (i == 0) ? l0 : ln;
    return r;
  endfunction

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] r;
    for (int i = 0; i < NL; i++) r[i*LW +: LW] = $urandom;
    return r;
  endfunction

  // Called at a falling edge with inputs set: score the handshakes that the
  // next rising edge will complete, then advance to the following falling edge.
  task automatic tick();
    logic [FW-1:0] act;
    logic [FW-1:0] e;
    logic [W-1:0]  d;
    bit            sat;
    if (m_axis_tvalid && m_axis_tready) begin
      act = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      cap_q.push_back(m_axis_tdata[LW-1:0]);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_beat: got %0h expected no beat", act);
      end else begin
        e = exp_q.pop_front();
        check("out_beat", act, e);
        if (e[FW-1]) m_pkt++;
      end
    end
    if (s_axis_tvalid && s_axis_tready) begin
      if (m_pkt_start) begin
        m_mode  = ctrl_mode;
        m_const = ctrl_constant;
      end
      d = model_op(m_mode, m_const, s_axis_tdata, sat);
      if (sat) m_sat++;
      exp_q.push_back({s_axis_tlast, s_axis_tkeep, d});
      m_pkt_start = s_axis_tlast;
    end
    @(negedge aclk);
  endtask

  task automatic send(input logic [W-1:0] d, input logic [KW-1:0] k, input logic l);
    int n = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got tready=0 for %0d cycles expected acceptance", n);
    end
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    while (exp_q.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    check("drain_done", exp_q.size(), 0);
    repeat (6) tick();
  endtask

  task automatic apply_reset();
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    exp_q.delete();
    m_pkt_start = 1'b1;
    m_sat       = 0;
    m_pkt       = 0;
    #1;
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_pkt_count", stat_pkt_count, 0);
    check("rst_sat_count", stat_sat_count, 0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("tready_before_first_edge", s_axis_tready, 0);
    @(posedge aclk);
    #1;
    check("tready_after_first_edge", s_axis_tready, 1);
    @(negedge aclk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] exp_seq[5];
    int            acc;
    bit            hold;
    bit            took;

    n_cmp = 0;
    n_fail = 0;
    aresetn = 1'b1;
    ctrl_mode = MODE_ADD;
    ctrl_constant = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tlast = 1'b0;
    m_axis_tready = 1'b0;
    m_pkt_start = 1'b1;
    m_mode = '0;
    m_const = '0;
    m_sat = 0;
    m_pkt = 0;

    //            mode         const         lane0         others        keep                    exp0          expn          sat
    vecs[0] = '{MODE_ADD,    32'h5,        32'hFFFFFFFE, 32'hFFFFFFFE, {KW{1'b1}},             32'h3,        32'h3,        0};
    vecs[1] = '{MODE_SATADD, 32'h10,       32'hFFFFFFF8, 32'h0,        64'h0000_0000_0000_000F, 32'hFFFFFFFF, 32'h10,       1};
    vecs[2] = '{MODE_SUB,    32'h1,        32'h0,        32'h12345678, 64'hF0F0_F0F0_F0F0_F0F0, 32'hFFFFFFFF, 32'h12345677, 0};
    vecs[3] = '{MODE_PASS,   32'hDEAD,     32'hCAFEBABE, 32'h7,        64'h8000_0000_0000_0001, 32'hCAFEBABE, 32'h7,        0};
    vecs[4] = '{MODE_SATADD, 32'h10,       32'hFFFFFFEF, 32'h1,        {KW{1'b1}},             32'hFFFFFFFF, 32'h11,       0};
    vecs[5] = '{MODE_SATADD, 32'hFFFFFFFF, 32'h0,        32'h1,        {KW{1'b1}},             32'hFFFFFFFF, 32'hFFFFFFFF, 1};
    vecs[6] = '{MODE_ADD,    32'h80000000, 32'h80000000, 32'h7FFFFFFF, 64'h0123_4567_89AB_CDEF, 32'h0,        32'hFFFFFFFF, 0};
    vecs[7] = '{MODE_SUB,    32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, {KW{1'b1}},             32'h1,        32'h0,        0};

    @(negedge aclk);
    apply_reset();

    // Directed single-beat packets: latency, lane results, pass-through, stats.
    for (int v = 0; v < 8; v++) begin : vec_loop
      int          lat;
      logic [31:0] sat0;
      logic [31:0] pkt0;
      logic [31:0] dsat;
      logic [31:0] dpkt;
      sat0 = stat_sat_count;
      pkt0 = stat_pkt_count;
      ctrl_mode      = vecs[v].mode;
      ctrl_constant  = vecs[v].cst;
      s_axis_tdata   = fill(vecs[v].lane0, vecs[v].lane_n);
      s_axis_tkeep   = vecs[v].keep;
      s_axis_tlast   = 1'b1;
      s_axis_tvalid  = 1'b1;
      m_axis_tready  = 1'b0;
      check("vec_tready", s_axis_tready, 1);
      tick();
      s_axis_tvalid = 1'b0;
      lat = 1;
      while (!m_axis_tvalid && lat < 20) begin
        tick();
        lat++;
      end
      check("vec_latency", lat, 3);
      check("vec_out", {m_axis_tlast, m_axis_tkeep, m_axis_tdata},
            {1'b1, vecs[v].keep, fill(vecs[v].exp0, vecs[v].expn)});
      m_axis_tready = 1'b1;
      tick();
      m_axis_tready = 1'b0;
      dsat = stat_sat_count - sat0;
      dpkt = stat_pkt_count - pkt0;
      check("vec_sat_delta", dsat, vecs[v].exp_sat);
      check("vec_pkt_delta", dpkt, 1);
    end

    // Control is latched on the first beat; a mid-packet switch has no effect.
    cap_q.delete();
    m_axis_tready = 1'b1;
    ctrl_constant = 32'd3;
    for (int b = 0; b < 4; b++) begin
      ctrl_mode = (b == 0) ? MODE_ADD : MODE_SUB;
      send(fill(32'd10, 32'd10), {KW{1'b1}}, (b == 3));
    end
    ctrl_mode = MODE_SUB;
    send(fill(32'd10, 32'd10), {KW{1'b1}}, 1'b1);
    drain();
    exp_seq = '{32'd13, 32'd13, 32'd13, 32'd13, 32'd7};
    check("latch_beat_count", cap_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < cap_q.size()) check("latch_lane0", cap_q[i], exp_seq[i]);
    end

    // Backpressure: exactly DEPTH beats accepted, then release and drain.
    cap_q.delete();
    m_axis_tready = 1'b0;
    ctrl_mode     = MODE_SUB;
    ctrl_constant = $urandom;
    acc = 0;
    s_axis_tdata  = rand_data();
    s_axis_tkeep  = {$urandom, $urandom};
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 80; c++) begin
      s_axis_tlast = ((acc % 4) == 3);
      took = s_axis_tready;
      tick();
      if (took) begin
        acc++;
        s_axis_tdata = rand_data();
        s_axis_tkeep = {$urandom, $urandom};
      end
    end
    check("bp_accepted", acc, DEPTH);
    check("bp_tready_low", s_axis_tready, 0);
    drain();
    check("bp_out_count", cap_q.size(), DEPTH);

    // Randomized traffic with per-cycle control churn and random backpressure.
    hold = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!hold) begin
        s_axis_tvalid = ($urandom_range(0, 9) < 7);
        s_axis_tdata  = rand_data();
        s_axis_tkeep  = {$urandom, $urandom};
        s_axis_tlast  = ($urandom_range(0, 3) == 0);
      end
      ctrl_mode     = 2'($urandom_range(0, 3));
      ctrl_constant = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      m_axis_tready = ($urandom_range(0, 9) < 7);
      hold = s_axis_tvalid && !s_axis_tready;
      tick();
    end
    drain();
    check("rand_pkt_count", stat_pkt_count, m_pkt);
    check("rand_sat_count", stat_sat_count, m_sat);

    // Reset with beats buffered mid-packet, then a fresh single-beat packet.
    m_axis_tready = 1'b0;
    ctrl_mode     = MODE_ADD;
    ctrl_constant = 32'd1;
    for (int b = 0; b < 10; b++) send(rand_data(), {KW{1'b1}}, 1'b0);
    repeat (4) tick();
    check("pre_reset_tvalid", m_axis_tvalid, 1);
    apply_reset();
    cap_q.delete();
    ctrl_mode     = MODE_SUB;
    ctrl_constant = 32'd2;
    m_axis_tready = 1'b1;
    send(fill(32'd9, 32'd9), {KW{1'b1}}, 1'b1);
    drain();
    check("post_reset_count", cap_q.size(), 1);
    if (cap_q.size() >= 1) check("post_reset_lane0", cap_q[0], 32'd7);
    check("post_reset_pkt", stat_pkt_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
